dpll_control: RTL and testbench
===============================

// Module: dpll_control
// PURPOSE
//  Top-level DPLL sequencer for the SAT accelerator. Makes branch decisions,
//  triggers BCP over each assigned variable's clause range and drains the
//  implication queue. On conflict it backtracks the trace stack and flips
//  decisions, then reports sat or unsat.
// PARAMETERS
//  MAX_VARS_BITS     `MAX_VARS_BITS     width of a variable index
//  MAX_CLAUSES_BITS  `MAX_CLAUSES_BITS  width of a clause index
//  NUM_VARS          2**MAX_VARS_BITS   variables 0..NUM_VARS-1 are decided
// PORTS
//  clock              in   1   single clock, rising edge
//  reset              in   1   asynchronous, active-high; clears all state
//  start              in   1   launch solve; sampled only in IDLE
//  bcp_busy           in   1   BCP core walking a clause range
//  conflict           in   1   BCP found a falsified clause; valid when bcp_busy=0
//  bcp_clause_idx     in   MCB conflicting clause; latched on conflict (debug only)
//  reset_bcp          out  1   1-cycle pulse: flush BCP core and imply queue
//  empty_imply        in   1   imply queue empty
//  var/val/type_out_imply in MVB/1/1  imply head (first-word fall-through)
//  pop_imply          out  1   dequeue imply head
//  empty_trace        in   1   trace stack empty
//  var/val/type_out_trace in MVB/1/1  trace top (fall-through); type 1=decision
//  pop_trace/push_trace  out 1 stack pop/push strobes
//  var/val/type_in_trace out MVB/1/1  entry to push
//  write_vs           out  1   var-state write strobe
//  var_in_vs/val_in_vs/unassign_in_vs out MVB/1/1  var-state write data
//  start_clause/end_clause in MCB  clause range from var start/end table, 1 cycle after read
//  read_var_start_end out  1   table read strobe
//  var_in_vse         out  MVB table read address
//  sat / unsat        out  1   sticky results, mutually exclusive
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, assigned bitmap and decision pointer dptr cleared.
//  Strobes are combinational from state and are 1 cycle wide. Data outputs are 0 when their strobe is low.
//  Internal NUM_VARS-bit assigned bitmap; cur_var register.
//  IDLE: start=1 -> DECIDE with dptr=0.
//  DECIDE: if dptr==NUM_VARS -> SAT.
//    If assigned[dptr], then dptr++ (1 var/cycle).
//    Otherwise: write_vs(var=dptr,val=0,unassign=0) and push_trace(dptr,0,type=1).
//    Set the bit and cur_var=dptr, then go to BCP_READ.
//  BCP_READ: read_var_start_end=1, var_in_vse=cur_var -> BCP_ARM.
//  BCP_ARM: sample start_clause/end_clause.
//    If start_clause>end_clause (empty range), skip BCP and go to NEXT; otherwise -> BCP_WAIT.
//    The core raises bcp_busy this cycle.
//  BCP_WAIT: hold while bcp_busy=1.
//    On bcp_busy=0: conflict=1 latches bcp_clause_idx -> BT_FLUSH; otherwise -> NEXT.
//  NEXT: if empty_imply=1 -> DECIDE. Otherwise pop_imply=1 and read the head.
//    - unassigned: write_vs(var,val), push_trace(var,val,type_out_imply), set bit,
//      cur_var=var -> BCP_READ.
//    - assigned, same value: drop and stay in NEXT.
//    - assigned, opposite value: -> BT_FLUSH. Control keeps a value bitmap alongside assigned.
//  BT_FLUSH: reset_bcp=1 -> BT_POP.
//  BT_POP: if empty_trace -> UNSAT. Otherwise pop_trace=1, write_vs(var_out_trace, unassign=1), clear bit.
//    type_out_trace=0 stays in BT_POP; type 1 latches var and val -> BT_FLIP.
//  BT_FLIP: write_vs(var,~val) and push_trace(var,~val,type=0).
//    Flips push as implied so they are never re-flipped. Set bit, dptr=0, cur_var=var -> BCP_READ.
//  SAT/UNSAT: output held at 1 until reset; start is ignored.
//  Push and pop never occur in the same cycle. pop_imply is never asserted when empty_imply=1.
//  pop_trace is never asserted when empty_trace=1.
//  Reset mid-operation aborts immediately to IDLE. External memories are cleared by their own reset.
// TESTING
//  Reset=1 -> all outputs 0. NUM_VARS=2, all ranges empty, start pulse
//    -> pushes (0,0,1) then (1,0,1), then sat=1 with unsat=0.
//  Conflict after deciding var0 -> reset_bcp pulse, pop var0 with unassign=1,
//    then push (0,1,0) with write_vs val=1.
//  Second conflict with trace entry (0,1,0) -> pop leaves trace empty -> unsat=1 sticky.
//  Imply head (3,1,0) after clean BCP -> pop_imply, write_vs var3=1, push (3,1,0),
//    read_var_start_end with var_in_vse=3.
//  Imply head contradicts an assigned var -> BT_FLUSH; pop only down to the last decision.
//  Reset asserted during BCP_WAIT -> outputs 0 at once; a later start re-solves.

Source files
------------

// File: rtl/dpll_control.sv
// ---------------------------------------------------------------------------
// dpll_control
//   Top-level DPLL sequencer for the SAT accelerator. It makes branch
//   decisions and triggers BCP over the clause range of each newly assigned
//   variable. It then drains the implication queue. On a conflict it unwinds
//   the trace stack down to the most recent decision and flips that decision.
//   The result is reported as sticky sat / unsat.
//
// Ports
//   clock, reset                  rising-edge clock, async active-high reset
//   start                         launch a solve (only looked at in IDLE)
//   bcp_busy / conflict           BCP core status; conflict valid when !bcp_busy
//   bcp_clause_idx                conflicting clause, latched into conflict_clause
//   reset_bcp                     1-cycle flush of BCP core and imply queue
//   empty_imply, *_out_imply      imply queue head (first-word fall-through)
//   pop_imply                     dequeue imply head
//   empty_trace, *_out_trace      trace stack top (fall-through), type 1=decision
//   pop_trace / push_trace        trace stack strobes, *_in_trace push data
//   write_vs, *_in_vs             variable-state memory write port
//   read_var_start_end, var_in_vse  clause-range table read (data 1 cycle later)
//   start_clause / end_clause     clause range returned by the table
//   sat / unsat                   sticky, mutually exclusive results
//   conflict_clause               last latched conflicting clause (debug)
// ---------------------------------------------------------------------------
module dpll_control #(
   parameter int MAX_VARS_BITS    = 2,
   parameter int MAX_CLAUSES_BITS = 4,
   parameter int NUM_VARS         = 2**MAX_VARS_BITS
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        bcp_busy,
   input  logic                        conflict,
   input  logic [MAX_CLAUSES_BITS-1:0] bcp_clause_idx,
   output logic                        reset_bcp,
   input  logic                        empty_imply,
   input  logic [MAX_VARS_BITS-1:0]    var_out_imply,
   input  logic                        val_out_imply,
   input  logic                        type_out_imply,
   output logic                        pop_imply,
   input  logic                        empty_trace,
   input  logic [MAX_VARS_BITS-1:0]    var_out_trace,
   input  logic                        val_out_trace,
   input  logic                        type_out_trace,
   output logic                        pop_trace,
   output logic                        push_trace,
   output logic [MAX_VARS_BITS-1:0]    var_in_trace,
   output logic                        val_in_trace,
   output logic                        type_in_trace,
   output logic                        write_vs,
   output logic [MAX_VARS_BITS-1:0]    var_in_vs,
   output logic                        val_in_vs,
   output logic                        unassign_in_vs,
   input  logic [MAX_CLAUSES_BITS-1:0] start_clause,
   input  logic [MAX_CLAUSES_BITS-1:0] end_clause,
   output logic                        read_var_start_end,
   output logic [MAX_VARS_BITS-1:0]    var_in_vse,
   output logic                        sat,
   output logic                        unsat,
   output logic [MAX_CLAUSES_BITS-1:0] conflict_clause
);

   localparam int MVB = MAX_VARS_BITS;
   localparam int MCB = MAX_CLAUSES_BITS;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DECIDE,
      S_BCP_READ,
      S_BCP_ARM,
      S_BCP_WAIT,
      S_NEXT,
      S_BT_FLUSH,
      S_BT_POP,
      S_BT_FLIP,
      S_SAT,
      S_UNSAT
   } state_t;

   // dptr is one bit wider than a variable index so it can reach NUM_VARS.
   localparam logic [MVB:0] DPTR_END = (MVB+1)'(NUM_VARS);

   state_t                state_q, state_d;
   logic [MVB:0]          dptr_q, dptr_d;
   logic [MVB-1:0]        cur_var_q, cur_var_d;
   logic [NUM_VARS-1:0]   assigned_q, assigned_d;
   logic [NUM_VARS-1:0]   value_q, value_d;
   logic [MVB-1:0]        flip_var_q, flip_var_d;
   logic                  flip_val_q, flip_val_d;
   logic                  sat_q, sat_d;
   logic                  unsat_q, unsat_d;
   logic [MCB-1:0]        conflict_clause_q, conflict_clause_d;
   logic [MVB-1:0]        dptr_idx;

   assign dptr_idx        = dptr_q[MVB-1:0];
   assign sat             = sat_q;
   assign unsat           = unsat_q;
   assign conflict_clause = conflict_clause_q;

   always_comb begin
      state_d            = state_q;
      dptr_d             = dptr_q;
      cur_var_d          = cur_var_q;
      assigned_d         = assigned_q;
      value_d            = value_q;
      flip_var_d         = flip_var_q;
      flip_val_d         = flip_val_q;
      sat_d              = sat_q;
      unsat_d            = unsat_q;
      conflict_clause_d  = conflict_clause_q;

      reset_bcp          = 1'b0;
      pop_imply          = 1'b0;
      pop_trace          = 1'b0;
      push_trace         = 1'b0;
      var_in_trace       = '0;
      val_in_trace       = 1'b0;
      type_in_trace      = 1'b0;
      write_vs           = 1'b0;
      var_in_vs          = '0;
      val_in_vs          = 1'b0;
      unassign_in_vs     = 1'b0;
      read_var_start_end = 1'b0;
      var_in_vse         = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dptr_d  = '0;
               state_d = S_DECIDE;
            end
         end

         S_DECIDE: begin
            if (dptr_q == DPTR_END) begin
               sat_d   = 1'b1;
               state_d = S_SAT;
            end else if (assigned_q[dptr_idx]) begin
               // Skip already-assigned variables one per cycle.
               dptr_d = dptr_q + 1'b1;
            end else begin
               // New decision: always try value 0 first.
               write_vs             = 1'b1;
               var_in_vs            = dptr_idx;
               push_trace           = 1'b1;
               var_in_trace         = dptr_idx;
               type_in_trace        = 1'b1;
               assigned_d[dptr_idx] = 1'b1;
               value_d[dptr_idx]    = 1'b0;
               cur_var_d            = dptr_idx;
               state_d              = S_BCP_READ;
            end
         end

         S_BCP_READ: begin
            read_var_start_end = 1'b1;
            var_in_vse         = cur_var_q;
            state_d            = S_BCP_ARM;
         end

         S_BCP_ARM: begin
            // start > end encodes a variable that appears in no clause.
            if (start_clause > end_clause) state_d = S_NEXT;
            else                           state_d = S_BCP_WAIT;
         end

         S_BCP_WAIT: begin
            if (!bcp_busy) begin
               if (conflict) begin
                  conflict_clause_d = bcp_clause_idx;
                  state_d           = S_BT_FLUSH;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end

         S_NEXT: begin
            if (empty_imply) begin
               state_d = S_DECIDE;
            end else begin
               pop_imply = 1'b1;
               if (!assigned_q[var_out_imply]) begin
                  write_vs                  = 1'b1;
                  var_in_vs                 = var_out_imply;
                  val_in_vs                 = val_out_imply;
                  push_trace                = 1'b1;
                  var_in_trace              = var_out_imply;
                  val_in_trace              = val_out_imply;
                  type_in_trace             = type_out_imply;
                  assigned_d[var_out_imply] = 1'b1;
                  value_d[var_out_imply]    = val_out_imply;
                  cur_var_d                 = var_out_imply;
                  state_d                   = S_BCP_READ;
               end else if (value_q[var_out_imply] != val_out_imply) begin
                  // Implication contradicts an existing assignment.
                  state_d = S_BT_FLUSH;
               end
               // Same value already assigned: the entry is simply dropped.
            end
         end

         S_BT_FLUSH: begin
            reset_bcp = 1'b1;
            state_d   = S_BT_POP;
         end

         S_BT_POP: begin
            if (empty_trace) begin
               // No decision left to flip: the formula is unsatisfiable.
               unsat_d = 1'b1;
               state_d = S_UNSAT;
            end else begin
               pop_trace                 = 1'b1;
               write_vs                  = 1'b1;
               var_in_vs                 = var_out_trace;
               unassign_in_vs            = 1'b1;
               assigned_d[var_out_trace] = 1'b0;
               if (type_out_trace) begin
                  flip_var_d = var_out_trace;
                  flip_val_d = val_out_trace;
                  state_d    = S_BT_FLIP;
               end
            end
         end

         S_BT_FLIP: begin
            // The flipped value is pushed as an implication (type 0) so a
            // later backtrack pops past it instead of flipping it again.
            write_vs               = 1'b1;
            var_in_vs              = flip_var_q;
            val_in_vs              = ~flip_val_q;
            push_trace             = 1'b1;
            var_in_trace           = flip_var_q;
            val_in_trace           = ~flip_val_q;
            type_in_trace          = 1'b0;
            assigned_d[flip_var_q] = 1'b1;
            value_d[flip_var_q]    = ~flip_val_q;
            dptr_d                 = '0;
            cur_var_d              = flip_var_q;
            state_d                = S_BCP_READ;
         end

         S_SAT, S_UNSAT: begin
            state_d = state_q;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q           <= S_IDLE;
         dptr_q            <= '0;
         cur_var_q         <= '0;
         assigned_q        <= '0;
         value_q           <= '0;
         flip_var_q        <= '0;
         flip_val_q        <= 1'b0;
         sat_q             <= 1'b0;
         unsat_q           <= 1'b0;
         conflict_clause_q <= '0;
      end else begin
         state_q           <= state_d;
         dptr_q            <= dptr_d;
         cur_var_q         <= cur_var_d;
         assigned_q        <= assigned_d;
         value_q           <= value_d;
         flip_var_q        <= flip_var_d;
         flip_val_q        <= flip_val_d;
         sat_q             <= sat_d;
         unsat_q           <= unsat_d;
         conflict_clause_q <= conflict_clause_d;
      end
   end

endmodule

// File: tb/tb_dpll_control.sv
// ---------------------------------------------------------------------------
// tb_dpll_control
//   Directed bench for dpll_control. The main instance has 4 variables and is
//   driven cycle by cycle against hand-derived strobe patterns. A second
//   2-variable instance with tied-off inputs runs the all-empty-range solve.
// ---------------------------------------------------------------------------
module tb_dpll_control;

   logic       clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- main DUT: 4 variables, 16 clauses ----------------
   logic       reset, start, bcp_busy, conflict;
   logic [3:0] bcp_clause_idx;
   logic       reset_bcp;
   logic       empty_imply;
   logic [1:0] var_out_imply;
   logic       val_out_imply, type_out_imply, pop_imply;
   logic       empty_trace;
   logic [1:0] var_out_trace;
   logic       val_out_trace, type_out_trace;
   logic       pop_trace, push_trace;
   logic [1:0] var_in_trace;
   logic       val_in_trace, type_in_trace;
   logic       write_vs;
   logic [1:0] var_in_vs;
   logic       val_in_vs, unassign_in_vs;
   logic [3:0] start_clause, end_clause;
   logic       read_var_start_end;
   logic [1:0] var_in_vse;
   logic       sat, unsat;
   logic [3:0] conflict_clause;

   dpll_control #(.MAX_VARS_BITS(2), .MAX_CLAUSES_BITS(4)) dut (
      .clock(clock), .reset(reset), .start(start), .bcp_busy(bcp_busy),
      .conflict(conflict), .bcp_clause_idx(bcp_clause_idx), .reset_bcp(reset_bcp),
      .empty_imply(empty_imply), .var_out_imply(var_out_imply),
      .val_out_imply(val_out_imply), .type_out_imply(type_out_imply),
      .pop_imply(pop_imply), .empty_trace(empty_trace),
      .var_out_trace(var_out_trace), .val_out_trace(val_out_trace),
      .type_out_trace(type_out_trace), .pop_trace(pop_trace),
      .push_trace(push_trace), .var_in_trace(var_in_trace),
      .val_in_trace(val_in_trace), .type_in_trace(type_in_trace),
      .write_vs(write_vs), .var_in_vs(var_in_vs), .val_in_vs(val_in_vs),
      .unassign_in_vs(unassign_in_vs), .start_clause(start_clause),
      .end_clause(end_clause), .read_var_start_end(read_var_start_end),
      .var_in_vse(var_in_vse), .sat(sat), .unsat(unsat),
      .conflict_clause(conflict_clause)
   );

   logic [17:0] obs;
   assign obs = {write_vs, var_in_vs, val_in_vs, unassign_in_vs,
                 push_trace, var_in_trace, val_in_trace, type_in_trace,
                 pop_trace, pop_imply, reset_bcp,
                 read_var_start_end, var_in_vse, sat, unsat};

   // ---------------- small DUT: 2 variables, inputs tied off ----------------
   logic       reset_s, start_s;
   logic       t_zero = 1'b0;
   logic       t_one  = 1'b1;
   logic [0:0] t_var  = 1'b0;
   logic [3:0] t_sc   = 4'd1;
   logic [3:0] t_ec   = 4'd0;
   logic [3:0] t_ci   = 4'd0;
   logic       reset_bcp_s, pop_imply_s, pop_trace_s, push_trace_s;
   logic [0:0] var_in_trace_s, var_in_vs_s, var_in_vse_s;
   logic       val_in_trace_s, type_in_trace_s, write_vs_s, val_in_vs_s;
   logic       unassign_in_vs_s, read_var_start_end_s, sat_s, unsat_s;
   logic [3:0] conflict_clause_s;

   dpll_control #(.MAX_VARS_BITS(1), .MAX_CLAUSES_BITS(4)) dut_s (
      .clock(clock), .reset(reset_s), .start(start_s), .bcp_busy(t_zero),
      .conflict(t_zero), .bcp_clause_idx(t_ci), .reset_bcp(reset_bcp_s),
      .empty_imply(t_one), .var_out_imply(t_var), .val_out_imply(t_zero),
      .type_out_imply(t_zero), .pop_imply(pop_imply_s), .empty_trace(t_one),
      .var_out_trace(t_var), .val_out_trace(t_zero), .type_out_trace(t_zero),
      .pop_trace(pop_trace_s), .push_trace(push_trace_s),
      .var_in_trace(var_in_trace_s), .val_in_trace(val_in_trace_s),
      .type_in_trace(type_in_trace_s), .write_vs(write_vs_s),
      .var_in_vs(var_in_vs_s), .val_in_vs(val_in_vs_s),
      .unassign_in_vs(unassign_in_vs_s), .start_clause(t_sc), .end_clause(t_ec),
      .read_var_start_end(read_var_start_end_s), .var_in_vse(var_in_vse_s),
      .sat(sat_s), .unsat(unsat_s), .conflict_clause(conflict_clause_s)
   );

   logic [14:0] obs_s;
   assign obs_s = {write_vs_s, var_in_vs_s, val_in_vs_s, unassign_in_vs_s,
                   push_trace_s, var_in_trace_s, val_in_trace_s, type_in_trace_s,
                   pop_trace_s, pop_imply_s, reset_bcp_s,
                   read_var_start_end_s, var_in_vse_s, sat_s, unsat_s};

   // ---------------- expected-pattern builders ----------------
   function automatic logic [17:0] ex(
      input logic wvs, input logic [1:0] wv, input logic wval, input logic wun,
      input logic psh, input logic [1:0] pv, input logic pval, input logic ptyp,
      input logic ptr, input logic pimp, input logic rbcp,
      input logic rd, input logic [1:0] rv, input logic s, input logic u);
      return {wvs, wv, wval, wun, psh, pv, pval, ptyp, ptr, pimp, rbcp, rd, rv, s, u};
   endfunction

   function automatic logic [17:0] ex_wp(input logic [1:0] v, input logic val, input logic typ);
      return ex(1'b1, v, val, 1'b0, 1'b1, v, val, typ, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
   endfunction

   function automatic logic [17:0] ex_wpi(input logic [1:0] v, input logic val, input logic typ);
      return ex(1'b1, v, val, 1'b0, 1'b1, v, val, typ, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
   endfunction

   function automatic logic [17:0] ex_rd(input logic [1:0] v);
      return ex(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v, 1'b0, 1'b0);
   endfunction

   function automatic logic [17:0] ex_pop(input logic [1:0] v);
      return ex(1'b1, v, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
   endfunction

   localparam logic [17:0] EX_NONE  = 18'd0;
   localparam logic [17:0] EX_FLUSH = 18'b0_00_0_0_0_00_0_0_0_0_1_0_00_0_0;
   localparam logic [17:0] EX_PIMP  = 18'b0_00_0_0_0_00_0_0_0_1_0_0_00_0_0;
   localparam logic [17:0] EX_UNSAT = 18'b0_00_0_0_0_00_0_0_0_0_0_0_00_0_1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; bcp_busy = 1'b0; conflict = 1'b0; bcp_clause_idx = 4'd0;
      empty_imply = 1'b1; var_out_imply = 2'd0; val_out_imply = 1'b0; type_out_imply = 1'b0;
      empty_trace = 1'b1; var_out_trace = 2'd0; val_out_trace = 1'b0; type_out_trace = 1'b0;
      start_clause = 4'd1; end_clause = 4'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      reset = 1'b1; reset_s = 1'b1; start_s = 1'b0;
      tick();
      #1;
      n_tests++; if (obs !== EX_NONE) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, EX_NONE); end
      n_tests++; if (obs_s !== 15'd0) begin n_fail++; $display("FAIL reset_outputs_small: got %h want 0", obs_s); end
      n_tests++; if (conflict_clause !== 4'd0) begin n_fail++; $display("FAIL reset_conflict_clause: got %h want 0", conflict_clause); end
      tick();
      reset = 1'b0; reset_s = 1'b0;
      tick();
   endtask

   task automatic test_sat_two_vars();
      logic [0:0] rv [4];
      logic       rval [4];
      logic       rtyp [4];
      int         n_push;
      n_push = 0;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      for (int i = 0; i < 60 && !sat_s; i++) begin
         #1;
         if (push_trace_s && n_push < 4) begin
            rv[n_push] = var_in_trace_s; rval[n_push] = val_in_trace_s; rtyp[n_push] = type_in_trace_s;
            n_push++;
         end
         tick();
      end
      n_tests++; if (sat_s !== 1'b1) begin n_fail++; $display("FAIL sat_reached: got %b want 1", sat_s); end
      n_tests++; if (unsat_s !== 1'b0) begin n_fail++; $display("FAIL sat_unsat_excl: got %b want 0", unsat_s); end
      n_tests++; if (n_push !== 2) begin n_fail++; $display("FAIL sat_push_count: got %0d want 2", n_push); end
      if (n_push >= 2) begin
         n_tests++; if ({rv[0], rval[0], rtyp[0]} !== 3'b001) begin n_fail++; $display("FAIL sat_push0: got %b want 001", {rv[0], rval[0], rtyp[0]}); end
         n_tests++; if ({rv[1], rval[1], rtyp[1]} !== 3'b101) begin n_fail++; $display("FAIL sat_push1: got %b want 101", {rv[1], rval[1], rtyp[1]}); end
      end
      start_s = 1'b1;
      tick();
      tick();
      start_s = 1'b0;
      #1;
      n_tests++; if (obs_s !== 15'b000000000000010) begin n_fail++; $display("FAIL sat_sticky: got %b want 000000000000010", obs_s); end
   endtask

   task automatic test_conflict_flip();
      do_reset();
      start_clause = 4'd0; end_clause = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      n_tests++; if (obs !== ex_wp(2'd0, 1'b0, 1'b1)) begin n_fail++; $display("FAIL cf_decide0: got %h want %h", obs, ex_wp(2'd0, 1'b0, 1'b1)); end
      tick(); #1;
      n_tests++; if (obs !== ex_rd(2'd0)) begin n_fail++; $display("FAIL cf_read0: got %h want %h", obs, ex_rd(2'd0)); end
      tick(); bcp_busy = 1'b1; #1;
      n_tests++; if (obs !== EX_NONE) begin n_fail++; $display("FAIL cf_arm: got %h want %h", obs, EX_NONE); end
      tick(); #1;
      n_tests++; if (obs !== EX_NONE) begin n_fail++; $display("FAIL cf_wait: got %h want %h", obs, EX_NONE); end
      bcp_busy = 1'b0; conflict = 1'b1; bcp_clause_idx = 4'd5;
      tick();
      conflict = 1'b0; bcp_clause_idx = 4'd0;
      empty_trace = 1'b0; var_out_trace = 2'd0; val_out_trace = 1'b0; type_out_trace = 1'b1;
      #1;
      n_tests++; if (obs !== EX_FLUSH) begin n_fail++; $display("FAIL cf_flush: got %h want %h", obs, EX_FLUSH); end
      n_tests++; if (conflict_clause !== 4'd5) begin n_fail++; $display("FAIL cf_clause_latch: got %0d want 5", conflict_clause); end
      tick(); #1;
      n_tests++; if (obs !== ex_pop(2'd0)) begin n_fail++; $display("FAIL cf_pop0: got %h want %h", obs, ex_pop(2'd0)); end
      tick(); empty_trace = 1'b1; #1;
      n_tests++; if (obs !== ex_wp(2'd0, 1'b1, 1'b0)) begin n_fail++; $display("FAIL cf_flip0: got %h want %h", obs, ex_wp(2'd0, 1'b1, 1'b0)); end
      tick(); #1;
      n_tests++; if (obs !== ex_rd(2'd0)) begin n_fail++; $display("FAIL cf_read_after_flip: got %h want %h", obs, ex_rd(2'd0)); end
   endtask

   // Continues from the state left by test_conflict_flip (trace holds (0,1,0)).
   task automatic test_unsat();
      tick(); bcp_busy = 1'b1;
      tick(); bcp_busy = 1'b0; conflict = 1'b1; bcp_clause_idx = 4'd7;
      tick();
      conflict = 1'b0;
      empty_trace = 1'b0; var_out_trace = 2'd0; val_out_trace = 1'b1; type_out_trace = 1'b0;
      #1;
      n_tests++; if (obs !== EX_FLUSH) begin n_fail++; $display("FAIL un_flush: got %h want %h", obs, EX_FLUSH); end
      tick(); #1;
      n_tests++; if (obs !== ex_pop(2'd0)) begin n_fail++; $display("FAIL un_pop_implied: got %h want %h", obs, ex_pop(2'd0)); end
      tick(); empty_trace = 1'b1; #1;
      n_tests++; if (obs !== EX_NONE) begin n_fail++; $display("FAIL un_no_pop_empty: got %h want %h", obs, EX_NONE); end
      tick(); #1;
      n_tests++; if (obs !== EX_UNSAT) begin n_fail++; $display("FAIL un_unsat: got %h want %h", obs, EX_UNSAT); end
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      #1;
      n_tests++; if (obs !== EX_UNSAT) begin n_fail++; $display("FAIL un_sticky: got %h want %h", obs, EX_UNSAT); end
   endtask

   task automatic test_imply();
      do_reset();
      #1;
      n_tests++; if (obs !== EX_NONE) begin n_fail++; $display("FAIL im_reset_clears_unsat: got %h want %h", obs, EX_NONE); end
      start_clause = 4'd0; end_clause = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      n_tests++; if (obs !== ex_wp(2'd0, 1'b0, 1'b1)) begin n_fail++; $display("FAIL im_decide0: got %h want %h", obs, ex_wp(2'd0, 1'b0, 1'b1)); end
      tick();
      tick(); bcp_busy = 1'b1;
      tick();
      tick(); #1;
      n_tests++; if (obs !== EX_NONE) begin n_fail++; $display("FAIL im_wait_hold: got %h want %h", obs, EX_NONE); end
      bcp_busy = 1'b0;
      empty_imply = 1'b0; var_out_imply = 2'd3; val_out_imply = 1'b1; type_out_imply = 1'b0;
      tick(); #1;
      n_tests++; if (obs !== ex_wpi(2'd3, 1'b1, 1'b0)) begin n_fail++; $display("FAIL im_pop_assign3: got %h want %h", obs, ex_wpi(2'd3, 1'b1, 1'b0)); end
      tick(); empty_imply = 1'b1; #1;
      n_tests++; if (obs !== ex_rd(2'd3)) begin n_fail++; $display("FAIL im_read3: got %h want %h", obs, ex_rd(2'd3)); end
   endtask

   // Continues from test_imply: var0=0 (decision), var3=1 (implied).
   task automatic test_contradiction();
      start_clause = 4'd1; end_clause = 4'd0;
      tick();
      empty_imply = 1'b0; var_out_imply = 2'd3; val_out_imply = 1'b1; type_out_imply = 1'b0;
      tick(); #1;
      n_tests++; if (obs !== EX_PIMP) begin n_fail++; $display("FAIL ct_drop_same: got %h want %h", obs, EX_PIMP); end
      tick(); var_out_imply = 2'd0; val_out_imply = 1'b1; #1;
      n_tests++; if (obs !== EX_PIMP) begin n_fail++; $display("FAIL ct_contra_pop: got %h want %h", obs, EX_PIMP); end
      tick();
      empty_imply = 1'b1;
      empty_trace = 1'b0; var_out_trace = 2'd3; val_out_trace = 1'b1; type_out_trace = 1'b0;
      #1;
      n_tests++; if (obs !== EX_FLUSH) begin n_fail++; $display("FAIL ct_flush: got %h want %h", obs, EX_FLUSH); end
      tick(); #1;
      n_tests++; if (obs !== ex_pop(2'd3)) begin n_fail++; $display("FAIL ct_pop3: got %h want %h", obs, ex_pop(2'd3)); end
      tick(); var_out_trace = 2'd0; val_out_trace = 1'b0; type_out_trace = 1'b1; #1;
      n_tests++; if (obs !== ex_pop(2'd0)) begin n_fail++; $display("FAIL ct_pop0: got %h want %h", obs, ex_pop(2'd0)); end
      tick(); empty_trace = 1'b1; #1;
      n_tests++; if (obs !== ex_wp(2'd0, 1'b1, 1'b0)) begin n_fail++; $display("FAIL ct_flip0: got %h want %h", obs, ex_wp(2'd0, 1'b1, 1'b0)); end
      tick(); #1;
      n_tests++; if (obs !== ex_rd(2'd0)) begin n_fail++; $display("FAIL ct_read0: got %h want %h", obs, ex_rd(2'd0)); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      start_clause = 4'd0; end_clause = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick(); bcp_busy = 1'b1;
      tick();
      // Now in BCP_WAIT; abort asynchronously and present a conflict that
      // would trigger a flush if the sequencer had not returned to IDLE.
      reset = 1'b1; bcp_busy = 1'b0; conflict = 1'b1;
      #1;
      n_tests++; if (obs !== EX_NONE) begin n_fail++; $display("FAIL rm_async_outputs: got %h want %h", obs, EX_NONE); end
      tick();
      reset = 1'b0;
      tick(); #1;
      n_tests++; if (obs !== EX_NONE) begin n_fail++; $display("FAIL rm_idle_after: got %h want %h", obs, EX_NONE); end
      conflict = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      n_tests++; if (obs !== ex_wp(2'd0, 1'b0, 1'b1)) begin n_fail++; $display("FAIL rm_resolve_decide0: got %h want %h", obs, ex_wp(2'd0, 1'b0, 1'b1)); end
      tick(); #1;
      n_tests++; if (obs !== ex_rd(2'd0)) begin n_fail++; $display("FAIL rm_resolve_read0: got %h want %h", obs, ex_rd(2'd0)); end
   endtask

   initial begin
      test_reset();
      test_sat_two_vars();
      test_conflict_flip();
      test_unsat();
      test_imply();
      test_contradiction();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
      $fatal(1, "watchdog");
   end

endmodule
